// File: rtl/flush_controller_pkg.sv
// Shared definitions for the mispredict recovery path: state encoding,
// default address width and the hold-counter width helper.
package flush_controller_pkg;

  // Default instruction address width, shared with the predictor and IF.
  localparam int DEFAULT_ADDR_WIDTH = 32;

  // Recovery sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } flush_state_e;

  // Bits needed to hold values 0..hold-1, never less than one bit.
  function automatic int hold_cnt_width(input int hold);
    int w;
    w = $clog2(hold);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage : flush_controller_pkg

// File: rtl/flush_hold_counter.sv
// Down-counter timing the flush hold window. Loaded with FLUSH_HOLD-1 when
// the sequencer enters FLUSH, decremented while the window is still open.
module flush_hold_counter
  import flush_controller_pkg::*;
#(
  parameter int FLUSH_HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int HOLD_W = hold_cnt_width(FLUSH_HOLD);
  localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(FLUSH_HOLD - 1);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // Next count: load wins over decrement; everything frozen while rdy is low.
  always_comb begin
    cnt_d = cnt_q;
    if (!rdy) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != {HOLD_W{1'b0}})) begin
      cnt_d = cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {HOLD_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {HOLD_W{1'b0}});

endmodule : flush_hold_counter

// File: rtl/flush_controller.sv
// Mispredict recovery sequencer. Stalls commit, waits for committed stores
// to drain, broadcasts flush for a fixed window, then redirects fetch.
// This block is the only driver of the *_flush nets.
module flush_controller
  import flush_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  mispredict,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  store_pending,
  input  logic                  redirect_ack,
  output logic                  commit_stall,
  output logic                  if_flush,
  output logic                  lsb_flush,
  output logic                  rob_flush,
  output logic                  rs_flush,
  output logic                  cdb_flush,
  output logic                  register_flush,
  output logic                  if_redirect_valid,
  output logic [ADDR_WIDTH-1:0] if_redirect_addr,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  flush_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  stall_q;
  logic                  flush_q;
  logic                  redir_valid_q;
  logic                  busy_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic hold_load;
  logic hold_dec;
  logic hold_zero;

  // Hold counter is loaded on the DRAIN->FLUSH edge and counts down in FLUSH.
  assign hold_load = (state_q == ST_DRAIN) && !store_pending;
  assign hold_dec  = (state_q == ST_FLUSH) && !hold_zero;

  flush_hold_counter #(
    .FLUSH_HOLD (FLUSH_HOLD)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .load_i (hold_load),
    .dec_i  (hold_dec),
    .zero_o (hold_zero)
  );

  // Recovery FSM with Moore outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= {CNT_WIDTH{1'b0}};
    end else if (rdy) begin
      // A mispredict arriving while a recovery is in flight is a protocol
      // violation; it is dropped and the sticky error raised.
      if (mispredict && (state_q != ST_IDLE)) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (mispredict) begin
            state_q <= ST_DRAIN;
            addr_q  <= redirect_addr;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (!store_pending) begin
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
          end else begin
            state_q <= ST_DRAIN;
          end
        end

        ST_FLUSH: begin
          if (hold_zero) begin
            state_q       <= ST_REDIRECT;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b1;
          end else begin
            state_q <= ST_FLUSH;
          end
        end

        ST_REDIRECT: begin
          if (redirect_ack) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            busy_q        <= 1'b0;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
              count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              count_q <= count_q;
            end
          end else begin
            state_q <= ST_REDIRECT;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          stall_q       <= 1'b0;
          flush_q       <= 1'b0;
          redir_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  assign commit_stall      = stall_q;
  assign if_flush          = flush_q;
  assign lsb_flush         = flush_q;
  assign rob_flush         = flush_q;
  assign rs_flush          = flush_q;
  assign cdb_flush         = flush_q;
  assign register_flush    = flush_q;
  assign if_redirect_valid = redir_valid_q;
  // Address is only presented while the redirect request is up.
  assign if_redirect_addr  = redir_valid_q ? addr_q : {ADDR_WIDTH{1'b0}};
  assign busy              = busy_q;
  assign protocol_err      = err_q;
  assign flush_count       = count_q;

endmodule : flush_controller
